key_event_queue: RTL and testbench

KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

---
 rtl/key_event_pkg.sv | 33 +++
 rtl/key_event_fifo.sv | 68 ++++++
 rtl/key_event_queue.sv | 155 +++++++++++++++
 tb/tb_key_event_queue.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// Shared definitions for the PS/2 key event queue.
// Holds the prefix FSM state type, the event width, PS/2 prefix/status codes,
// the scan codes of the tracked modifier keys and the strobe bit positions
// used inside key_event_queue.
package key_event_pkg;

    localparam int unsigned EventWidth = 10;

    // Prefix/status bytes reported by the PS/2 receiver
    localparam logic [7:0] CodeExt     = 8'hE0;
    localparam logic [7:0] CodeRelease = 8'hF0;
    localparam logic [7:0] CodeSelfOk  = 8'hAA;

    // Modifier scan codes (ctrl/alt share codes between left and E0 right)
    localparam logic [7:0] KeyLShift = 8'h12;
    localparam logic [7:0] KeyRShift = 8'h59;
    localparam logic [7:0] KeyCtrl   = 8'h14;
    localparam logic [7:0] KeyAlt    = 8'h11;

    // Bit positions of the upstream strobes in the synchronizer vector
    localparam int unsigned StbLatch = 0;
    localparam int unsigned StbRel   = 1;
    localparam int unsigned StbExt   = 2;
    localparam int unsigned StbRst   = 3;

    typedef enum logic [1:0] {
        StIdle,
        StExt,
        StRel,
        StExtRel
    } prefix_state_e;

endpackage

// File: rtl/key_event_fifo.sv
// First-word-fall-through FIFO for key events.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   push_i, push_data_i write request/data (ignored when full without pop)
//   pop_i              read request (ignored when empty)
//   pop_data_o         oldest entry, zero when empty
//   full_o, empty_o    status
//   count_o            occupancy, 0..DEPTH
module key_event_fifo
    import key_event_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [EventWidth-1:0]      push_data_i,
    input  logic                       pop_i,
    output logic [EventWidth-1:0]      pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

    logic [EventWidth-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]         count_q, count_d;
    logic                  do_push, do_pop;

    assign full_o  = (count_q == FullCount);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Pop only real data; a full FIFO still accepts a push that coincides with a pop.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/key_event_queue.sv
// PS/2 key event queue: synchronizes receiver strobes, folds E0/F0 prefixes
// into {extended, release, code} events and buffers them in a FIFO.
// Optional feature macro: KEY_EVENT_MODIFIER_TRACK_EN enables shift/ctrl/alt
// tracking on mod_state; otherwise mod_state is tied to zero.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   data[10:0]               PS/2 frame, scan byte in data[8:1]
//   data_latch, release_key,
//   extended_code,
//   reset_required           receiver strobes (asynchronous to clk)
//   ev_data/ev_valid/ev_ready event stream (FWFT)
//   ev_count                 FIFO occupancy
//   overflow                 sticky drop flag
//   kbd_reset                one-cycle pulse on 0xAA
//   mod_state                {alt, ctrl, shift}
module key_event_queue
    import key_event_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [10:0]                data,
    input  logic                       data_latch,
    input  logic                       release_key,
    input  logic                       extended_code,
    input  logic                       reset_required,
    output logic [EventWidth-1:0]      ev_data,
    output logic                       ev_valid,
    input  logic                       ev_ready,
    output logic [$clog2(DEPTH):0]     ev_count,
    output logic                       overflow,
    output logic                       kbd_reset,
    output logic [2:0]                 mod_state
);

    logic [3:0]                    strobes;
    logic [SYNC_STAGES-1:0][3:0]   sync_q;
    logic [3:0]                    prev_q, edge_d, edge_q;
    logic [7:0]                    code_q;
    prefix_state_e                 state_q, state_d;
    logic                          push, pop, full, empty;
    logic                          ext_flag, rel_flag;
    logic                          overflow_q, overflow_d;
    logic [EventWidth-1:0]         push_data;
    logic                          unused_frame;

    assign unused_frame = ^{data[10:9], data[0]};

    assign strobes[StbLatch] = data_latch;
    assign strobes[StbRel]   = release_key;
    assign strobes[StbExt]   = extended_code;
    assign strobes[StbRst]   = reset_required;

    assign edge_d = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Edges are registered so the FSM works on one clean pulse per strobe;
    // the scan byte is captured alongside the data_latch edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= '0;
            edge_q <= '0;
            code_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], strobes};
            prev_q <= sync_q[SYNC_STAGES-1];
            edge_q <= edge_d;
            if (edge_d[StbLatch]) code_q <= data[8:1];
        end
    end

    assign ext_flag  = (state_q == StExt) || (state_q == StExtRel);
    assign rel_flag  = (state_q == StRel) || (state_q == StExtRel);
    assign push_data = {ext_flag, rel_flag, code_q};
    assign pop       = ev_valid & ev_ready;

    // Priority: reset_required > data_latch > extended_code > release_key
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        if (edge_q[StbRst]) begin
            state_d = StIdle;
        end else if (edge_q[StbLatch]) begin
            push    = 1'b1;
            state_d = StIdle;
        end else if (edge_q[StbExt]) begin
            if (state_q == StIdle)     state_d = StExt;
            else if (state_q == StRel) state_d = StExtRel;
        end else if (edge_q[StbRel]) begin
            if (state_q == StIdle)     state_d = StRel;
            else if (state_q == StExt) state_d = StExtRel;
        end
    end

    assign overflow_d = overflow_q | (push & full & ~pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign kbd_reset = edge_q[StbRst];
    assign ev_valid  = ~empty;

    key_event_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .pop_data_o  (ev_data),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (ev_count)
    );

`ifdef KEY_EVENT_MODIFIER_TRACK_EN
    logic [2:0] mod_q, mod_d;

    // Tracks every decoded key event, including ones dropped on a full FIFO.
    always_comb begin
        mod_d = mod_q;
        if (edge_q[StbRst]) begin
            mod_d = '0;
        end else if (push) begin
            case (code_q)
                KeyLShift, KeyRShift: if (!ext_flag) mod_d[0] = ~rel_flag;
                KeyCtrl:              mod_d[1] = ~rel_flag;
                KeyAlt:               mod_d[2] = ~rel_flag;
                default:              mod_d = mod_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) mod_q <= '0;
        else     mod_q <= mod_d;
    end

    assign mod_state = mod_q;
`else
    assign mod_state = '0;
`endif

endmodule

// File: tb/tb_key_event_queue.sv
module tb_key_event_queue;

    localparam int unsigned DEPTH       = 8;
    localparam int unsigned SYNC_STAGES = 2;
`ifdef KEY_EVENT_MODIFIER_TRACK_EN
    localparam bit ModEn = 1'b1;
`else
    localparam bit ModEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] data;
    logic        data_latch, release_key, extended_code, reset_required;
    logic [9:0]  ev_data;
    logic        ev_valid, ev_ready;
    logic [3:0]  ev_count;
    logic        overflow, kbd_reset;
    logic [2:0]  mod_state;

    int checks = 0;
    int errors = 0;
    int kbd_pulses = 0;

    key_event_queue #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data           (data),
        .data_latch     (data_latch),
        .release_key    (release_key),
        .extended_code  (extended_code),
        .reset_required (reset_required),
        .ev_data        (ev_data),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_count       (ev_count),
        .overflow       (overflow),
        .kbd_reset      (kbd_reset),
        .mod_state      (mod_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (kbd_reset) kbd_pulses++;

    typedef struct {
        logic       ext_first;
        logic       ext;
        logic       rel;
        logic [7:0] code;
        logic [9:0] exp;
    } vec_t;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // which: 0 data_latch, 1 release_key, 2 extended_code, 3 reset_required
    task automatic strobe(input int which, input logic [7:0] code);
        data = {1'b1, 1'b0, code, 1'b0};
        case (which)
            0: data_latch = 1'b1;
            1: release_key = 1'b1;
            2: extended_code = 1'b1;
            default: reset_required = 1'b1;
        endcase
        step(2);
        data_latch = 1'b0;
        release_key = 1'b0;
        extended_code = 1'b0;
        reset_required = 1'b0;
        step(6);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic pop_one();
        ev_ready = 1'b1;
        step(1);
        ev_ready = 1'b0;
    endtask

    vec_t vecs [6];
    int   pulses0;

    initial begin
        rst = 1'b1;
        data = '0;
        data_latch = 1'b0;
        release_key = 1'b0;
        extended_code = 1'b0;
        reset_required = 1'b0;
        ev_ready = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h1C, 10'h01C};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 8'h75, 10'h375};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h75, 10'h075};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 8'hFF, 10'h2FF};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 8'h5A, 10'h15A};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 8'h6B, 10'h36B};

        step(2);
        rst = 1'b0;
        step(1);
        check("reset ev_valid", ev_valid, 0);
        check("reset ev_count", ev_count, 0);
        check("reset overflow", overflow, 0);
        check("reset kbd_reset", kbd_reset, 0);
        check("reset mod_state", mod_state, 0);
        check("reset ev_data", ev_data, 0);

        // Latency of a single make code into an empty FIFO
        data = {1'b1, 1'b0, 8'h1C, 1'b0};
        data_latch = 1'b1;
        step(SYNC_STAGES + 1);
        check("latency early", ev_valid, 0);
        step(1);
        check("latency valid", ev_valid, 1);
        check("latency data", ev_data, 10'h01C);
        data_latch = 1'b0;
        step(6);
        check("single count", ev_count, 1);
        pop_one();
        check("single drained", ev_valid, 0);

        // Prefix combinations from the vector table
        foreach (vecs[i]) begin
            if (vecs[i].ext_first) begin
                if (vecs[i].ext) strobe(2, 8'hE0);
                if (vecs[i].rel) strobe(1, 8'hF0);
            end else begin
                if (vecs[i].rel) strobe(1, 8'hF0);
                if (vecs[i].ext) strobe(2, 8'hE0);
            end
            strobe(0, vecs[i].code);
            check($sformatf("vec%0d count", i), ev_count, 1);
            check($sformatf("vec%0d data", i), ev_data, vecs[i].exp);
            pop_one();
            check($sformatf("vec%0d empty", i), ev_count, 0);
        end

        // Push and pop in the same cycle on an empty FIFO must not bypass
        ev_ready = 1'b1;
        data = {1'b1, 1'b0, 8'h33, 1'b0};
        data_latch = 1'b1;
        step(SYNC_STAGES + 1);
        check("nobypass early", ev_valid, 0);
        step(1);
        check("nobypass valid", ev_valid, 1);
        check("nobypass data", ev_data, 10'h033);
        step(1);
        check("nobypass popped", ev_valid, 0);
        ev_ready = 1'b0;
        data_latch = 1'b0;
        step(6);

        // Pending prefix discarded by reset_required
        pulses0 = kbd_pulses;
        strobe(2, 8'hE0);
        strobe(3, 8'hAA);
        check("kbd_reset pulses", kbd_pulses - pulses0, 1);
        check("kbd_reset low", kbd_reset, 0);
        strobe(0, 8'h1C);
        check("after aa data", ev_data, 10'h01C);
        check("after aa count", ev_count, 1);
        pop_one();

        // Pending prefix discarded by rst
        strobe(1, 8'hF0);
        do_reset();
        strobe(0, 8'h1C);
        check("after rst data", ev_data, 10'h01C);
        pop_one();

        // Modifier tracking
        strobe(0, 8'h12);
        check("shift make", mod_state, ModEn ? 3'b001 : 3'b000);
        strobe(1, 8'hF0);
        strobe(0, 8'h12);
        check("shift break", mod_state, 0);
        strobe(2, 8'hE0);
        strobe(0, 8'h14);
        check("rctrl make", mod_state, ModEn ? 3'b010 : 3'b000);
        strobe(0, 8'h11);
        check("alt make", mod_state, ModEn ? 3'b110 : 3'b000);
        strobe(3, 8'hAA);
        check("aa clears mods", mod_state, 0);
        check("fifo kept on aa", ev_count, 4);
        do_reset();

        // Overflow: ninth event dropped, first eight drained in order
        for (int i = 1; i <= 9; i++) strobe(0, 8'(i));
        check("ovf count", ev_count, 8);
        check("ovf flag", overflow, 1);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("ovf drain%0d", i), ev_data, 10'(i));
            pop_one();
        end
        check("ovf empty", ev_valid, 0);
        check("ovf sticky", overflow, 1);
        do_reset();
        check("ovf cleared", overflow, 0);

        // Full FIFO, push and pop in the same cycle
        for (int i = 1; i <= 8; i++) strobe(0, 8'h20 + 8'(i));
        check("full count", ev_count, 8);
        check("full no ovf", overflow, 0);
        data = {1'b1, 1'b0, 8'h30, 1'b0};
        data_latch = 1'b1;
        step(SYNC_STAGES + 1);
        ev_ready = 1'b1;
        step(1);
        ev_ready = 1'b0;
        check("pushpop count", ev_count, 8);
        check("pushpop ovf", overflow, 0);
        data_latch = 1'b0;
        step(6);
        check("pushpop settled", ev_count, 8);
        for (int i = 2; i <= 8; i++) begin
            check($sformatf("pushpop drain%0d", i), ev_data, 10'h020 + 10'(i));
            pop_one();
        end
        check("pushpop last", ev_data, 10'h030);
        pop_one();
        check("pushpop empty", ev_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
